move_entry_ctrl: RTL and testbench



---
 rtl/move_entry_ctrl_pkg.sv | 38 +++
 rtl/move_entry_ctrl_btn_debounce.sv | 62 ++++++
 rtl/move_entry_ctrl.sv | 138 +++++++++++++
 tb/tb_move_entry_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/move_entry_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : move_entry_ctrl_pkg
// Purpose  : Shared encodings and helpers for the tic-tac-toe move entry path.
// Revision : 1.0 - initial release
// ============================================================================
package move_entry_ctrl_pkg;

    localparam int BOARD_DIM = 3;

    typedef enum logic [1:0] {
        GS_PLAY = 2'b00,
        GS_WIN1 = 2'b01,
        GS_WIN0 = 2'b10,
        GS_DRAW = 2'b11
    } game_state_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_COMMIT = 2'b01,
        ST_SETTLE = 2'b10,
        ST_LOCKED = 2'b11
    } fsm_state_e;

    // Bit positions of the buttons inside the packed button bus.
    localparam int BTN_UP      = 0;
    localparam int BTN_DOWN    = 1;
    localparam int BTN_LEFT    = 2;
    localparam int BTN_RIGHT   = 3;
    localparam int BTN_CONFIRM = 4;
    localparam int NUM_BTNS    = 5;

    function automatic logic [3:0] cell_index(input logic [1:0] row_i, input logic [1:0] col_i);
        return 4'(int'(row_i) * BOARD_DIM + int'(col_i));
    endfunction

endpackage
`default_nettype wire

// File: rtl/move_entry_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Registers one raw button, debounces it and emits a press pulse.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int              CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             r_sample;
    logic             r_level;
    logic             r_press;
    logic             r_armed;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_toggle;

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_toggle  = (r_sample != r_level) && (w_cnt_inc == C_CNT_MAX);

    // The sample resets high and presses stay disarmed until a low sample is
    // seen, so a button held through reset cannot fire until it is re-pressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample <= 1'b1;
            r_level  <= 1'b0;
            r_press  <= 1'b0;
            r_armed  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sample <= raw;
            r_press  <= 1'b0;
            if (!r_sample) begin
                r_armed <= 1'b1;
            end
            if (r_sample == r_level) begin
                r_cnt <= '0;
            end else if (w_toggle) begin
                r_cnt   <= '0;
                r_level <= r_sample;
                r_press <= r_sample & r_armed;
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/move_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : move_entry_ctrl
// Purpose  : Button-driven cursor and legal-move strobe for the 3x3 board.
// Revision : 1.0 - initial release
// ============================================================================
module move_entry_ctrl
    import move_entry_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_confirm,
    input  logic [8:0] board_valid,
    input  logic [1:0] game_state,
    output logic [1:0] row,
    output logic [1:0] col,
    output logic       set,
    output logic       reject,
    output logic       locked
);

    localparam logic [1:0] C_LAST = 2'(BOARD_DIM - 1);

    logic [NUM_BTNS-1:0] w_raw;
    logic [NUM_BTNS-1:0] w_press;
    logic [NUM_BTNS-1:0] w_levels_unused;

    fsm_state_e r_state;
    fsm_state_e w_state_next;
    logic       w_move_en;
    logic       w_reject_next;
    logic       w_cell_taken;
    logic [1:0] w_row_next;
    logic [1:0] w_col_next;
    logic [1:0] r_row;
    logic [1:0] r_col;
    logic       r_set;
    logic       r_reject;
    logic       r_locked;

    assign w_raw = {btn_confirm, btn_right, btn_left, btn_down, btn_up};

    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .raw  (w_raw[gi]),
            .level(w_levels_unused[gi]),
            .press(w_press[gi])
        );
    end

    assign w_cell_taken = board_valid[cell_index(r_row, r_col)];

    // Game-over check outranks every event; confirm outranks cursor moves.
    always_comb begin
        w_state_next  = r_state;
        w_reject_next = 1'b0;
        w_move_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (game_state != GS_PLAY) begin
                    w_state_next = ST_LOCKED;
                end else if (w_press[BTN_CONFIRM]) begin
                    if (w_cell_taken) begin
                        w_reject_next = 1'b1;
                    end else begin
                        w_state_next = ST_COMMIT;
                    end
                end else begin
                    w_move_en = 1'b1;
                end
            end
            ST_COMMIT: w_state_next = ST_SETTLE;
            ST_SETTLE: w_state_next = ST_IDLE;
            ST_LOCKED: begin
                w_move_en     = 1'b1;
                w_reject_next = w_press[BTN_CONFIRM];
                if (game_state == GS_PLAY) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Opposing presses in one cycle cancel on their own axis only.
    always_comb begin
        w_row_next = r_row;
        w_col_next = r_col;
        if (w_move_en) begin
            if (w_press[BTN_UP] && !w_press[BTN_DOWN]) begin
                w_row_next = (r_row == 2'd0) ? C_LAST : r_row - 2'd1;
            end else if (w_press[BTN_DOWN] && !w_press[BTN_UP]) begin
                w_row_next = (r_row == C_LAST) ? 2'd0 : r_row + 2'd1;
            end
            if (w_press[BTN_LEFT] && !w_press[BTN_RIGHT]) begin
                w_col_next = (r_col == 2'd0) ? C_LAST : r_col - 2'd1;
            end else if (w_press[BTN_RIGHT] && !w_press[BTN_LEFT]) begin
                w_col_next = (r_col == C_LAST) ? 2'd0 : r_col + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_row    <= 2'd0;
            r_col    <= 2'd0;
            r_set    <= 1'b0;
            r_reject <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_row    <= w_row_next;
            r_col    <= w_col_next;
            r_set    <= (w_state_next == ST_COMMIT);
            r_reject <= w_reject_next;
            r_locked <= (w_state_next == ST_LOCKED);
        end
    end

    assign row    = r_row;
    assign col    = r_col;
    assign set    = r_set;
    assign reject = r_reject;
    assign locked = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_move_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_entry_ctrl
// Purpose  : Directed, table-driven self-checking bench for move_entry_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_entry_ctrl;

    localparam logic [4:0] C_U = 5'b00001;
    localparam logic [4:0] C_D = 5'b00010;
    localparam logic [4:0] C_L = 5'b00100;
    localparam logic [4:0] C_R = 5'b01000;
    localparam logic [4:0] C_C = 5'b10000;

    typedef struct {
        logic [4:0] btn;
        logic [8:0] bv;
        logic [1:0] gs;
        int         row;
        int         col;
        int         sets;
        int         rejs;
        int         lck;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up, btn_down, btn_left, btn_right, btn_confirm;
    logic [8:0] board_valid;
    logic [1:0] game_state;
    logic [1:0] row, col;
    logic       set, reject, locked;

    int errors = 0;
    int checks = 0;
    int n_set  = 0;
    int n_rej  = 0;
    int n_viol = 0;
    logic prev_set = 1'b0;

    vec_t vecs[$];

    move_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_confirm(btn_confirm),
        .board_valid(board_valid),
        .game_state (game_state),
        .row        (row),
        .col        (col),
        .set        (set),
        .reject     (reject),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (set)    n_set++;
        if (reject) n_rej++;
        if ((set && reject) || (set && prev_set)) begin
            n_viol++;
            $display("FAIL pulse_rule at %0t: set=%0b reject=%0b prev_set=%0b", $time, set, reject, prev_set);
        end
        prev_set = set;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive_btns(input logic [4:0] m);
        {btn_confirm, btn_right, btn_left, btn_down, btn_up} = m;
    endtask

    task automatic press(input logic [4:0] m, input int hold);
        drive_btns(m);
        repeat (hold) tick();
        drive_btns(5'b0);
        repeat (10) tick();
    endtask

    function automatic vec_t mk(input logic [4:0] b, input logic [8:0] bv, input logic [1:0] gs,
                                input int r, input int c, input int s, input int j, input int l);
        vec_t v;
        v.btn = b; v.bv = bv; v.gs = gs;
        v.row = r; v.col = c; v.sets = s; v.rejs = j; v.lck = l;
        return v;
    endfunction

    initial begin
        int s0, r0;

        // Cursor walk starting at (0,0).
        vecs.push_back(mk(C_R,       9'd0, 2'b00, 0, 1, 0, 0, 0));
        vecs.push_back(mk(C_R,       9'd0, 2'b00, 0, 2, 0, 0, 0));
        vecs.push_back(mk(C_R,       9'd0, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(C_R,       9'd0, 2'b00, 0, 1, 0, 0, 0));
        vecs.push_back(mk(C_U,       9'd0, 2'b00, 2, 1, 0, 0, 0));
        vecs.push_back(mk(C_U | C_D, 9'd0, 2'b00, 2, 1, 0, 0, 0));
        vecs.push_back(mk(C_U | C_L, 9'd0, 2'b00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(C_D | C_R, 9'd0, 2'b00, 2, 1, 0, 0, 0));
        vecs.push_back(mk(C_L,       9'd0, 2'b00, 2, 0, 0, 0, 0));
        vecs.push_back(mk(C_L,       9'd0, 2'b00, 2, 2, 0, 0, 0));
        vecs.push_back(mk(C_D,       9'd0, 2'b00, 0, 2, 0, 0, 0));
        vecs.push_back(mk(C_U,       9'd0, 2'b00, 2, 2, 0, 0, 0));
        vecs.push_back(mk(C_U,       9'd0, 2'b00, 1, 2, 0, 0, 0));
        vecs.push_back(mk(C_L,       9'd0, 2'b00, 1, 1, 0, 0, 0));
        // Confirms: occupied centre, empty, locked variants, unlock.
        vecs.push_back(mk(C_C,       9'b000010000, 2'b00, 1, 1, 0, 1, 0));
        vecs.push_back(mk(C_C,       9'd0,         2'b00, 1, 1, 1, 0, 0));
        vecs.push_back(mk(C_R,       9'd0,         2'b01, 1, 2, 0, 0, 1));
        vecs.push_back(mk(C_C,       9'd0,         2'b01, 1, 2, 0, 1, 1));
        vecs.push_back(mk(C_C,       9'd0,         2'b11, 1, 2, 0, 1, 1));
        vecs.push_back(mk(C_L,       9'd0,         2'b10, 1, 1, 0, 0, 1));
        vecs.push_back(mk(C_C,       9'd0,         2'b00, 1, 1, 1, 0, 0));
        vecs.push_back(mk(C_C | C_R, 9'd0,         2'b00, 1, 1, 1, 0, 0));
        vecs.push_back(mk(C_C,       9'b111111111, 2'b00, 1, 1, 0, 1, 0));
        vecs.push_back(mk(C_C,       9'b000100000, 2'b00, 1, 1, 1, 0, 0));
        vecs.push_back(mk(C_D,       9'd0,         2'b00, 2, 1, 0, 0, 0));
        vecs.push_back(mk(C_R,       9'd0,         2'b00, 2, 2, 0, 0, 0));
        vecs.push_back(mk(C_C,       9'b100000000, 2'b00, 2, 2, 0, 1, 0));

        reset = 1'b1;
        drive_btns(5'b0);
        board_valid = 9'd0;
        game_state  = 2'b00;
        repeat (3) tick();
        chk("reset_row", int'(row), 0);
        chk("reset_col", int'(col), 0);
        chk("reset_set", int'(set), 0);
        chk("reset_reject", int'(reject), 0);
        chk("reset_locked", int'(locked), 0);
        reset = 1'b0;
        repeat (5) tick();

        // Confirm latency: set only in the cycle after edge e+5.
        btn_confirm = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            tick();
            chk($sformatf("latency_set_k%0d", k), int'(set), (k == 5) ? 1 : 0);
            if (k == 5) begin
                chk("latency_reject", int'(reject), 0);
                chk("latency_row", int'(row), 0);
                chk("latency_col", int'(col), 0);
            end
        end
        btn_confirm = 1'b0;
        repeat (10) tick();

        // Three-sample glitch is filtered; a long hold gives a single move.
        press(C_R, 3);
        chk("glitch_col", int'(col), 0);
        press(C_R, 30);
        chk("long_hold_col", int'(col), 1);
        press(C_L, 5);
        chk("back_left_col", int'(col), 0);

        foreach (vecs[i]) begin
            board_valid = vecs[i].bv;
            game_state  = vecs[i].gs;
            tick();
            tick();
            s0 = n_set;
            r0 = n_rej;
            press(vecs[i].btn, 5);
            chk($sformatf("v%0d_row", i),    int'(row),    vecs[i].row);
            chk($sformatf("v%0d_col", i),    int'(col),    vecs[i].col);
            chk($sformatf("v%0d_sets", i),   n_set - s0,   vecs[i].sets);
            chk($sformatf("v%0d_rejs", i),   n_rej - r0,   vecs[i].rejs);
            chk($sformatf("v%0d_locked", i), int'(locked), vecs[i].lck);
        end

        // locked follows game_state within one edge in both directions.
        board_valid = 9'd0;
        game_state  = 2'b01;
        tick();
        chk("lock_one_cycle", int'(locked), 1);
        game_state = 2'b00;
        tick();
        chk("unlock_one_cycle", int'(locked), 0);
        tick();

        // Reset lands on the edge that would enter COMMIT; confirm held after.
        s0 = n_set;
        r0 = n_rej;
        btn_confirm = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk("rst_commit_set", int'(set), 0);
        chk("rst_commit_row", int'(row), 0);
        chk("rst_commit_col", int'(col), 0);
        tick();
        reset = 1'b0;
        repeat (20) tick();
        chk("held_reset_sets", n_set - s0, 0);
        chk("held_reset_rejs", n_rej - r0, 0);
        btn_confirm = 1'b0;
        repeat (10) tick();
        s0 = n_set;
        press(C_C, 5);
        chk("repress_sets", n_set - s0, 1);

        chk("pulse_rule_violations", n_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors + n_viol, checks);
        $finish;
    end

endmodule
`default_nettype wire
